// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: host-side word handshake for the UART transmit sequencer
interface uart_tx_ctrl_if #(
    parameter int FRAME_WIDTH = 8
);
    logic [FRAME_WIDTH-1:0] tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer, one frame per accepted word, one bit per cnt_done
module uart_tx_ctrl #(
    parameter int FRAME_WIDTH = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_ctrl_if.slave host,
    input  logic          cnt_done,
    output logic          cnt_en,
    output logic          tx,
    output logic          tx_busy,
    output logic          tx_done
);
    localparam int IW = $clog2(FRAME_WIDTH + 1);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
    logic [2:0]             state;
    logic [FRAME_WIDTH-1:0] shreg;
    logic [IW-1:0]          idx;
    logic                   stop_cnt;
    logic                   par;
    logic                   last_bit;
    logic                   last_stop;
    assign last_bit  = idx == IW'(FRAME_WIDTH - 1);
    assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shreg         <= '0;
            idx           <= '0;
            stop_cnt      <= 1'b0;
            par           <= 1'b0;
            tx            <= 1'b1;
            cnt_en        <= 1'b0;
            host.tx_ready <= 1'b1;
            tx_busy       <= 1'b0;
            tx_done       <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: if (host.tx_valid && host.tx_ready) begin
                    shreg         <= host.tx_data;
                    par           <= ^host.tx_data ^ (PARITY_ODD != 0);
                    state         <= START;
                    tx            <= 1'b0;
                    cnt_en        <= 1'b1;
                    host.tx_ready <= 1'b0;
                    tx_busy       <= 1'b1;
                end
                START: if (cnt_done) begin
                    state <= DATA;
                    idx   <= '0;
                    tx    <= shreg[0];
                end
                DATA: if (cnt_done) begin
                    shreg <= shreg >> 1;
                    // the next line value is shreg[1] because the shift lands on this same edge
                    if (last_bit) begin
                        state    <= PARITY_EN != 0 ? PARITY : STOP;
                        tx       <= PARITY_EN != 0 ? par : 1'b1;
                        stop_cnt <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                        tx  <= shreg[1];
                    end
                end
                PARITY: if (cnt_done) begin
                    state    <= STOP;
                    stop_cnt <= 1'b0;
                    tx       <= 1'b1;
                end
                STOP: if (cnt_done) begin
                    if (last_stop) begin
                        state         <= IDLE;
                        cnt_en        <= 1'b0;
                        host.tx_ready <= 1'b1;
                        tx_busy       <= 1'b0;
                        tx_done       <= 1'b1;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for four parameterisations of uart_tx_ctrl sharing one clock/reset
module tb_uart_tx_ctrl;
    localparam int B = 16;
    localparam int PE [4] = '{0, 1, 1, 0};
    localparam int PO [4] = '{0, 0, 1, 0};
    localparam int SB [4] = '{1, 1, 1, 2};
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data [4];
    logic       valid [4];
    logic       inject [4];
    logic       ready [4];
    logic       cnt_done [4];
    logic       cnt_en [4];
    logic       tx [4];
    logic       busy [4];
    logic       done [4];
    logic [15:0] sb_q [4][$];
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // transmitted bit i of a frame sits at bit i; stop bits are the trailing ones
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int i);
        logic [15:0] f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (PE[i] != 0) f[9] = (^d) ^ (PO[i] != 0);
        return f;
    endfunction
    for (genvar g = 0; g < 4; g++) begin : g_inst
        uart_tx_ctrl_if #(.FRAME_WIDTH(8)) bus();
        int   cnt = 0;
        logic tick = 1'b0;
        assign bus.tx_valid = valid[g];
        assign bus.tx_data  = data[g];
        assign ready[g]     = bus.tx_ready;
        assign cnt_done[g]  = tick | inject[g];
        always_ff @(posedge clk) begin
            if (!cnt_en[g]) begin
                cnt  <= 0;
                tick <= 1'b0;
            end else begin
                tick <= cnt == B - 1;
                cnt  <= cnt == B - 1 ? 0 : cnt + 1;
            end
        end
        uart_tx_ctrl #(
            .FRAME_WIDTH(8), .PARITY_EN(PE[g]), .PARITY_ODD(PO[g]), .STOP_BITS(SB[g])
        ) dut (
            .clk(clk), .rst_n(rst_n), .host(bus), .cnt_done(cnt_done[g]),
            .cnt_en(cnt_en[g]), .tx(tx[g]), .tx_busy(busy[g]), .tx_done(done[g])
        );
        initial begin
            int k = 0;
            int b;
            int n = 1 + 8 + PE[g] + SB[g];
            logic [15:0] m = (16'd1 << n) - 16'd1;
            logic [15:0] obs = '1;
            logic [15:0] seen = '0;
            logic [15:0] exp;
            logic bad = 1'b0;
            logic pb = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    sb_q[g].delete();
                    pb = 1'b0;
                    continue;
                end
                if (busy[g] && !pb) begin
                    k = 0; obs = '1; seen = '0; bad = 1'b0;
                end else if (busy[g] || done[g]) begin
                    k++;
                end
                if (busy[g]) begin
                    b = k == 0 ? 0 : (k - 1) / B;
                    if (b < 16) begin
                        if (!seen[b]) begin
                            obs[b] = tx[g];
                            seen[b] = 1'b1;
                        end else if (obs[b] !== tx[g]) begin
                            bad = 1'b1;
                        end
                    end
                end
                if (done[g]) begin
                    if (sb_q[g].size() == 0) begin
                        chk($sformatf("inst%0d unexpected tx_done", g), 0, 1);
                    end else begin
                        exp = sb_q[g].pop_front();
                        chk($sformatf("inst%0d frame bits", g), obs & m, exp & m);
                        chk($sformatf("inst%0d tx_done cycle", g), k, n * B + 1);
                        chk($sformatf("inst%0d bits stable", g), bad, 0);
                        chk($sformatf("inst%0d ready+tx at done", g), {ready[g], tx[g]}, 2'b11);
                    end
                end
                pb = busy[g];
            end
        end
    end
    task automatic send(input int i, input logic [7:0] d, input bit inj);
        int n = 0;
        @(negedge clk);
        while (!ready[i] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("inst%0d ready wait", i), ready[i], 1);
        data[i] = d;
        valid[i] = 1'b1;
        inject[i] = inj;
        @(posedge clk);
        sb_q[i].push_back(frame_bits(d, i));
        #1;
        valid[i] = 1'b0;
        inject[i] = 1'b0;
    endtask
    task automatic wait_done(input int i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < 1000);
        chk($sformatf("inst%0d done wait", i), done[i], 1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 4; i++) begin
            data[i] = 8'h00;
            valid[i] = 1'b0;
            inject[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("inst%0d reset values", i), {tx[i], cnt_en[i], ready[i], busy[i], done[i]}, 5'b10100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        inject[0] = 1'b1;
        @(negedge clk);
        inject[0] = 1'b0;
        @(negedge clk);
        chk("cnt_done in idle", {tx[0], cnt_en[0], ready[0], busy[0]}, 4'b1010);
        send(0, 8'hA5, 1'b1);
        wait_done(0);
        @(negedge clk);
        data[0] = 8'h00;
        valid[0] = 1'b1;
        @(posedge clk);
        sb_q[0].push_back(frame_bits(8'h00, 0));
        #1 data[0] = 8'hFF;
        wait_done(0);
        chk("b2b gap line", {tx[0], cnt_en[0], ready[0]}, 3'b101);
        @(posedge clk);
        sb_q[0].push_back(frame_bits(8'hFF, 0));
        @(negedge clk);
        chk("b2b second accept", {busy[0], cnt_en[0], tx[0]}, 3'b110);
        valid[0] = 1'b0;
        wait_done(0);
        send(0, 8'h3C, 1'b0);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            valid[0] = ~valid[0];
            data[0] = data[0] ^ 8'hFF;
            chk("ready low while busy", ready[0], 0);
        end
        valid[0] = 1'b0;
        wait_done(0);
        send(0, 8'h30, 1'b0);
        repeat (4 * B + 8) @(negedge clk);
        chk("data bit3 before reset", tx[0], 0);
        #2 rst_n = 1'b0;
        #1 chk("async reset outputs", {tx[0], cnt_en[0], ready[0], busy[0]}, 4'b1010);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", {tx[0], ready[0], busy[0]}, 3'b110);
        send(0, 8'hC3, 1'b0);
        wait_done(0);
        send(1, 8'h07, 1'b0);
        wait_done(1);
        send(2, 8'h07, 1'b0);
        wait_done(2);
        send(3, 8'hA5, 1'b0);
        wait_done(3);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("inst%0d scoreboard drained", i), sb_q[i].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit sequencer for the serial TX path. Accepts one data word per frame over a valid/ready handshake and gates the paired baud counter through `cnt_en`. Advances the serial line one bit per `cnt_done` pulse: start bit, data LSB first, optional parity, then one or two stop bits. Sits between the host-side byte source and the `tx` pin.

## Interface

- `FRAME_WIDTH`, 8, number of data bits per frame (5..9).
- `PARITY_EN`, 0, 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0, when `PARITY_EN`=1: 0 selects even parity, 1 selects odd parity.
- `STOP_BITS`, 1, number of stop bits (1 or 2).
- `clk` input 1: system clock. The block uses one clock; all state is on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `tx_data` input FRAME_WIDTH: word to send. Sampled only on the accept edge.
- `tx_valid` input 1: source has a word.
- `tx_ready` output 1: block can accept a word. High only in IDLE.
- `cnt_done` input 1: one-cycle pulse from the baud counter marking the end of a bit period.
- `cnt_en` output 1: baud counter enable. Held high for the whole frame.
- `tx` output 1: serial line. Idles high.
- `tx_busy` output 1: frame in progress.
- `tx_done` output 1: one-cycle pulse when the final stop bit ends.

## Operation

- **Baud counter contract.** While `cnt_en`=1, the counter gives a registered one-cycle `cnt_done` every BIT_COUNT cycles. The first pulse arrives BIT_COUNT edges after `cnt_en` first goes high. When `cnt_en`=0, the counter clears.
- **States:** IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- **IDLE**
  - Outputs: `tx`=1, `cnt_en`=0, `tx_ready`=1, `tx_busy`=0.
  - When `tx_valid` and `tx_ready` are both high at an edge (the accept edge):
    - latch `tx_data` into the shift register;
    - compute parity: XOR of the data bits, inverted when `PARITY_ODD`=1;
    - go to START.
- **START:** `tx`=0, `cnt_en`=1, `tx_ready`=0, `tx_busy`=1. On `cnt_done`, go to DATA with bit index 0.
- **DATA**
  - `tx` = shift register bit 0.
  - On each `cnt_done`: shift right and increment the bit index.
  - The bit index is a counter of width clog2(FRAME_WIDTH+1). It runs 0..FRAME_WIDTH-1 and does not wrap past FRAME_WIDTH-1.
  - On `cnt_done` with index = FRAME_WIDTH-1: go to PARITY if `PARITY_EN`=1, otherwise STOP.
- **PARITY:** `tx` = the latched parity bit. On `cnt_done`, go to STOP.
- **STOP**
  - `tx`=1, with a stop counter 0..STOP_BITS-1.
  - On `cnt_done` before the last stop bit: increment the stop counter.
  - On `cnt_done` with the last stop bit:
    - go to IDLE;
    - `cnt_en`=0, `tx_ready`=1, `tx_busy`=0 on that same edge;
    - `tx_done`=1 for exactly one cycle.
- **Boundary conditions**
  - `tx_valid` while `tx_ready`=0: ignored. The source must hold its word.
  - `tx_data` changing mid-frame: no effect on the frame.
  - `cnt_done` in IDLE: ignored.
  - `cnt_done` on the accept edge: ignored. START has not been entered yet.
  - `rst_n` low at any time, including mid-frame: asynchronously forces IDLE and all reset values. `tx` returns high immediately, so the line is never left low. Any partial frame is discarded.
- **Reset values:** `tx`=1, `cnt_en`=0, `tx_ready`=1, `tx_busy`=0, `tx_done`=0. The shift register, bit index and stop counter clear to 0.

## Timing

- Let E0 be the accept edge and B = BIT_COUNT.
- After E0: `tx`=0, `cnt_en`=1, `tx_busy`=1, `tx_ready`=0.
- The first `cnt_done` is high after edge E(B). The controller samples it at E(B+1).
- Every `tx` transition happens on the edge where `cnt_done` is sampled high. Bit boundaries therefore fall at E(B+1), E(2B+1), E(3B+1), and so on.
- Bit durations:
  - start bit: B+1 cycles;
  - every later bit: B cycles.
- Frame bit count N = 1 + FRAME_WIDTH + PARITY_EN + STOP_BITS.
- The frame ends at E(N·B+1). On that edge: `tx_done`=1 and `tx_ready`=1.
- **Back-to-back frames:** a new word may be accepted at E(N·B+1)+1 at the earliest. This gives a minimum of 1 idle cycle between frames, with `cnt_en` low for at least 1 cycle, which clears the counter.
- `tx_done` and the `tx_ready` rise are coincident.

## Test plan

- **Default frame, 0xA5.** Bench counter B=16, default parameters, one frame of 0xA5.
  - `tx` sequence (start, data LSB first, stop): 0, 1,0,1,0,0,1,0,1, 1.
  - Bit boundaries at cycles 17, 33, …, 161 after the accept edge.
  - `tx_done` high at cycle 161.
- **Even parity.** `PARITY_EN`=1, `PARITY_ODD`=0, 0x07: parity bit = 1 and N=11. With `PARITY_ODD`=1, the same word gives parity bit = 0.
- **Back-to-back.** `tx_valid` held high with 0x00 then 0xFF.
  - Second accept happens exactly 1 cycle after `tx_done`.
  - `tx` high during that 1-cycle gap.
  - No data corruption.
  - `cnt_en` low for exactly 1 cycle.
- **Busy interference.** Toggle `tx_valid` and `tx_data` while `tx_busy`=1. Require `tx_ready`=0 and the transmitted word unchanged.
- **Mid-frame reset.** Pulse `rst_n` low during data bit 3.
  - `tx`=1 and `cnt_en`=0 with no clock edge.
  - After release: IDLE, `tx_ready`=1, and the next frame is correct.
- **Two stop bits.** `STOP_BITS`=2, B=16, 8N2 frame: `tx` high for 32 cycles before `tx_done`, and N=11.
